// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a small input FIFO.
// Data width, parity and stop bits are configurable; producer uses valid/ready.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 10000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          nreset_i,
  input  logic [DATA_W-1:0]             tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              push;
  logic              pop;
  logic              empty;

  state_t            state;
  state_t            state_n;
  logic [BW-1:0]     baud;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              tx_n;
  logic              bit_done;
  logic              last_data;
  logic              last_stop;

  assign empty        = level == '0;
  assign tx_ready_o   = level != LW'(FIFO_DEPTH);
  assign push         = tx_valid_i && tx_ready_o;
  assign fifo_level_o = level;
  assign busy_o       = (state != S_IDLE) || !empty;

  assign bit_done  = baud == BW'(CLKS_PER_BIT - 1);
  assign last_data = bit_done && (bit_cnt == CW'(DATA_W - 1));
  assign last_stop = bit_done && (bit_cnt == CW'(STOP_BITS - 1));

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= tx_data_i;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_n;
      tx_o    <= tx_n;
      baud    <= (state == S_IDLE || bit_done) ? '0 : baud + 1'b1;
      bit_cnt <= (state_n != state) ? '0 : bit_cnt + CW'(bit_done);
      if (pop) begin
        shreg   <= mem[rd_ptr];
        par_bit <= (^mem[rd_ptr]) ^ (PARITY == 2);
      end else if (state == S_DATA && bit_done) begin
        shreg <= shreg >> 1;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (!empty)   state_n = S_START;
      S_START: if (bit_done) state_n = S_DATA;
      S_DATA:  if (last_data)
                 state_n = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (bit_done) state_n = S_STOP;
      S_STOP:  if (last_stop)
                 state_n = empty ? S_IDLE : S_START;
      default: state_n = S_IDLE;
    endcase
  end

  // tx_n is the level for the coming cycle, so tx_o is a clean flop.
  always_comb begin
    tx_n = 1'b1;
    pop  = !empty &&
           (state == S_IDLE || (state == S_STOP && last_stop));
    unique case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = (state == S_DATA && bit_done) ?
                      shreg[1] : shreg[0];
      S_PAR:   tx_n = par_bit;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, parity, FIFO flow and reset.
// Four instances cover default, even/odd parity and 7-bit/2-stop framing.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] v;
  logic [3:0] rdy;
  logic [3:0] tx;
  logic [3:0] busy;
  logic [8:0] d   [4];
  logic [2:0] lvl [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fst [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(16)) u0 (
    .clk_i(clk), .nreset_i(nreset),
    .tx_data_i(d[0][7:0]), .tx_valid_i(v[0]),
    .tx_ready_o(rdy[0]), .tx_o(tx[0]),
    .busy_o(busy[0]), .fifo_level_o(lvl[0])
  );

  uart_tx_fifo #(.CLKS_PER_BIT(16), .PARITY(1)) u1 (
    .clk_i(clk), .nreset_i(nreset),
    .tx_data_i(d[1][7:0]), .tx_valid_i(v[1]),
    .tx_ready_o(rdy[1]), .tx_o(tx[1]),
    .busy_o(busy[1]), .fifo_level_o(lvl[1])
  );

  uart_tx_fifo #(.CLKS_PER_BIT(16), .PARITY(2)) u2 (
    .clk_i(clk), .nreset_i(nreset),
    .tx_data_i(d[2][7:0]), .tx_valid_i(v[2]),
    .tx_ready_o(rdy[2]), .tx_o(tx[2]),
    .busy_o(busy[2]), .fifo_level_o(lvl[2])
  );

  uart_tx_fifo #(.CLKS_PER_BIT(16), .DATA_W(7), .STOP_BITS(2)) u3 (
    .clk_i(clk), .nreset_i(nreset),
    .tx_data_i(d[3][6:0]), .tx_valid_i(v[3]),
    .tx_ready_o(rdy[3]), .tx_o(tx[3]),
    .busy_o(busy[3]), .fifo_level_o(lvl[3])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push1(input int k, input logic [8:0] w, output int pc);
    @(negedge clk);
    d[k] = w;
    v[k] = 1'b1;
    @(negedge clk);
    pc   = cyc;
    v[k] = 1'b0;
  endtask

  task automatic expect_frame(input int k, input logic [8:0] w,
                              input int dw, input int par,
                              input int sb, input string tag,
                              input bit chk_end, output int st);
    int n;
    n = 0;
    while (tx[k] !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      st = -1;
      return;
    end
    st = cyc;
    repeat (8) @(negedge clk);
    check({tag, "_start"}, tx[k], 0);
    for (int i = 0; i < dw; i++) begin
      repeat (16) @(negedge clk);
      check($sformatf("%s_d%0d", tag, i), tx[k], w[i]);
    end
    if (par >= 0) begin
      repeat (16) @(negedge clk);
      check({tag, "_par"}, tx[k], par);
    end
    for (int i = 0; i < sb; i++) begin
      repeat (16) @(negedge clk);
      check($sformatf("%s_stop%0d", tag, i), tx[k], 1);
    end
    if (chk_end) begin
      repeat (7) @(negedge clk);
      check({tag, "_busy_last"}, busy[k], 1);
      @(negedge clk);
      check({tag, "_busy_end"}, busy[k], 0);
      check({tag, "_idle_tx"}, tx[k], 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int pc0;
    int st;
    int lows;
    v      = '0;
    nreset = 1'b0;
    for (int k = 0; k < 4; k++) d[k] = '0;
    #12;
    check("rst_tx",    tx[0],   1);
    check("rst_ready", rdy[0],  1);
    check("rst_busy",  busy[0], 0);
    check("rst_level", lvl[0],  0);
    @(negedge clk);
    nreset = 1'b1;

    push1(0, 9'h06C, pc);
    expect_frame(0, 9'h06C, 8, -1, 1, "t1", 1, st);
    check("t1_latency", st - pc, 1);

    push1(1, 9'h088, pc);
    expect_frame(1, 9'h088, 8, 0, 1, "t2e", 1, st);
    push1(2, 9'h088, pc);
    expect_frame(2, 9'h088, 8, 1, 1, "t2o", 1, st);

    push1(3, 9'h055, pc);
    expect_frame(3, 9'h055, 7, -1, 2, "t5", 1, st);

    fork
      begin
        for (int i = 0; i < 6; i++) begin
          expect_frame(0, 9'(i + 1), 8, -1, 1,
                       $sformatf("t3_f%0d", i), 0, fst[i]);
          if (i > 0)
            check($sformatf("t3_gap%0d", i), fst[i] - fst[i-1], 160);
        end
        repeat (8) @(negedge clk);
        check("t3_done_busy",  busy[0], 0);
        check("t3_done_level", lvl[0],  0);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          int n;
          if (i == 5) begin
            check("t3_full_level", lvl[0], 4);
            check("t3_full_ready", rdy[0], 0);
          end
          d[0] = 9'(i + 1);
          v[0] = 1'b1;
          n = 0;
          while (!rdy[0] && n < 400) begin
            @(negedge clk);
            n++;
          end
          if (n >= 400) check("t3_stall_timeout", 32'd0, 32'd1);
          if (i == 5) begin
            check("t3_rise_level", lvl[0], 3);
            check("t3_rise_cycle", cyc - fst[0], 160);
          end
          @(negedge clk);
        end
        v[0] = 1'b0;
        check("t6_refill_level", lvl[0], 4);
        check("t6_refill_ready", rdy[0], 0);
      end
    join

    push1(0, 9'h0F0, pc0);
    push1(0, 9'h0F0, pc);
    push1(0, 9'h0F0, pc);
    while (cyc < pc0 + 73) @(negedge clk);
    check("t4_pre_tx",    tx[0],  0);
    check("t4_pre_level", lvl[0], 2);
    nreset = 1'b0;
    #1;
    check("t4_rst_tx",    tx[0],   1);
    check("t4_rst_level", lvl[0],  0);
    check("t4_rst_ready", rdy[0],  1);
    check("t4_rst_busy",  busy[0], 0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) lows++;
    end
    check("t4_no_frame", lows, 0);
    check("t4_post_busy", busy[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
